// File: rtl/multicycle_sequencer_pkg.sv
// Shared opcode and sequencer state types for the multicycle control path.
// Holds the RV32 base opcodes the sequencer recognises and a legality helper.
package multicycle_sequencer_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'h03,
        OP_ITYPE  = 7'h13,
        OP_STORE  = 7'h23,
        OP_RTYPE  = 7'h33,
        OP_LUI    = 7'h37,
        OP_BRANCH = 7'h63,
        OP_JALR   = 7'h67,
        OP_JAL    = 7'h6F
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_TRAP    = 3'd5
    } state_e;

    localparam int unsigned INSTRET_W = 32;

    function automatic logic is_legal(input opcode_e op);
        case (op)
            OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JALR, OP_JAL, OP_LUI: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_sequencer_instret.sv
// Retired-instruction counter; built only when MULTICYCLE_SEQUENCER_INSTRET_EN is defined.
// Counts every cycle the sequencer strobes pc_we and wraps naturally at 2^32.
module instret_counter
    import multicycle_sequencer_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    output logic [INSTRET_W-1:0] count_o
);

    logic [INSTRET_W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + INSTRET_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with a sticky TRAP.
// Optional instret counter enabled by defining MULTICYCLE_SEQUENCER_INSTRET_EN.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  opcode_e              opcodes_i,
    input  logic                 branch_taken_i,
    output logic                 imem_req_o,
    input  logic                 imem_ack_i,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    input  logic                 dmem_ack_i,
    output logic                 ir_we_o,
    output logic                 pc_we_o,
    output logic                 regwrite_o,
    output logic                 illegal_o,
    output logic [2:0]           state_o,
    output logic [INSTRET_W-1:0] instret_o
);

    state_e state_q, state_d;

    // NOTE: non-blocking assignment for every flop so all state updates see pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_FETCH:   if (imem_ack_i) state_d = ST_DECODE;
            ST_DECODE:  state_d = is_legal(opcodes_i) ? ST_EXECUTE : ST_TRAP;
            ST_EXECUTE: begin
                if (opcodes_i == OP_LOAD || opcodes_i == OP_STORE) begin
                    state_d = ST_MEM;
                end else if (opcodes_i == OP_BRANCH) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM:     if (dmem_ack_i) state_d = (opcodes_i == OP_STORE) ? ST_FETCH : ST_WB;
            ST_WB:      state_d = ST_FETCH;
            ST_TRAP:    state_d = ST_TRAP;
            default:    state_d = ST_FETCH;
        endcase
    end

    // Branch target selection happens in the datapath; the sequencer only needs
    // to know the PC is written, so branch_taken_i does not affect control.
    logic unused_branch_taken;
    assign unused_branch_taken = branch_taken_i;

    always_comb begin
        imem_req_o = 1'b0;
        ir_we_o    = 1'b0;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        pc_we_o    = 1'b0;
        regwrite_o = 1'b0;
        illegal_o  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req_o = 1'b1;
                ir_we_o    = imem_ack_i;
            end
            ST_EXECUTE: pc_we_o = (opcodes_i == OP_BRANCH);
            ST_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = (opcodes_i == OP_STORE);
                pc_we_o    = dmem_ack_i && (opcodes_i == OP_STORE);
            end
            ST_WB: begin
                regwrite_o = 1'b1;
                pc_we_o    = 1'b1;
            end
            ST_TRAP:  illegal_o = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state_q;

`ifdef MULTICYCLE_SEQUENCER_INSTRET_EN
    instret_counter u_instret (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (pc_we_o),
        .count_o (instret_o)
    );
`else
    assign instret_o = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer; instret checks follow
// MULTICYCLE_SEQUENCER_INSTRET_EN (counter expected at 0 when it is undefined).
module tb_multicycle_sequencer;
    import multicycle_sequencer_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    opcode_e     opcodes_i;
    logic        branch_taken_i;
    logic        imem_req_o, imem_ack_i;
    logic        dmem_req_o, dmem_we_o, dmem_ack_i;
    logic        ir_we_o, pc_we_o, regwrite_o, illegal_o;
    logic [2:0]  state_o;
    logic [31:0] instret_o;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_ret = '0;

    // Expected strobe vector: {imem_req, ir_we, dmem_req, dmem_we, pc_we, regwrite, illegal}
    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_IMEM = 7'b1000000;
    localparam logic [6:0] S_IRWE = 7'b0100000;
    localparam logic [6:0] S_DREQ = 7'b0010000;
    localparam logic [6:0] S_DWE  = 7'b0001000;
    localparam logic [6:0] S_PCWE = 7'b0000100;
    localparam logic [6:0] S_RW   = 7'b0000010;
    localparam logic [6:0] S_ILL  = 7'b0000001;

    multicycle_sequencer dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .opcodes_i      (opcodes_i),
        .branch_taken_i (branch_taken_i),
        .imem_req_o     (imem_req_o),
        .imem_ack_i     (imem_ack_i),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_ack_i     (dmem_ack_i),
        .ir_we_o        (ir_we_o),
        .pc_we_o        (pc_we_o),
        .regwrite_o     (regwrite_o),
        .illegal_o      (illegal_o),
        .state_o        (state_o),
        .instret_o      (instret_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after the falling edge; outputs are then sampled 1 ns later.
    task automatic drive(input opcode_e op, input logic iack, input logic dack, input logic br);
        @(negedge clk_i);
        opcodes_i      = op;
        imem_ack_i     = iack;
        dmem_ack_i     = dack;
        branch_taken_i = br;
        #1;
    endtask

    task automatic expect_cycle(input string tag, input state_e st, input logic [6:0] strobes);
        check({tag, ".state"}, {29'd0, state_o}, {29'd0, st});
        check({tag, ".strobes"},
              {25'd0, imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, pc_we_o, regwrite_o, illegal_o},
              {25'd0, strobes});
        check({tag, ".instret"}, instret_o, exp_ret);
`ifdef MULTICYCLE_SEQUENCER_INSTRET_EN
        if (strobes[2]) exp_ret = exp_ret + 32'd1;
`endif
    endtask

    initial begin
        opcodes_i      = OP_RTYPE;
        imem_ack_i     = 1'b0;
        dmem_ack_i     = 1'b0;
        branch_taken_i = 1'b0;

        // Reset, then first cycle after release must be requesting a fetch.
        drive(OP_RTYPE, 1'b0, 1'b0, 1'b0); expect_cycle("rst",        ST_FETCH, S_IMEM);
        rst_ni = 1'b1;
        drive(opcode_e'(7'h7F), 1'b0, 1'b0, 1'b0); expect_cycle("fetch_wait", ST_FETCH, S_IMEM);

        // rtype, zero-wait; garbage opcode during FETCH and stray dmem acks ignored.
        drive(opcode_e'(7'h7F), 1'b1, 1'b0, 1'b0); expect_cycle("rtype.f",  ST_FETCH,   S_IMEM | S_IRWE);
        drive(OP_RTYPE, 1'b0, 1'b1, 1'b0);         expect_cycle("rtype.d",  ST_DECODE,  S_NONE);
        drive(OP_RTYPE, 1'b0, 1'b1, 1'b0);         expect_cycle("rtype.e",  ST_EXECUTE, S_NONE);
        drive(OP_RTYPE, 1'b0, 1'b0, 1'b0);         expect_cycle("rtype.wb", ST_WB,      S_RW | S_PCWE);

        // load with dmem_ack delayed 3 cycles: 8 cycles total.
        drive(OP_LOAD, 1'b1, 1'b0, 1'b0); expect_cycle("load.f",  ST_FETCH,   S_IMEM | S_IRWE);
        drive(OP_LOAD, 1'b0, 1'b0, 1'b0); expect_cycle("load.d",  ST_DECODE,  S_NONE);
        drive(OP_LOAD, 1'b0, 1'b0, 1'b0); expect_cycle("load.e",  ST_EXECUTE, S_NONE);
        for (int i = 0; i < 3; i++) begin
            drive(OP_LOAD, 1'b0, 1'b0, 1'b0); expect_cycle("load.mwait", ST_MEM, S_DREQ);
        end
        drive(OP_LOAD, 1'b0, 1'b1, 1'b0); expect_cycle("load.mack", ST_MEM,   S_DREQ);
        drive(OP_LOAD, 1'b0, 1'b0, 1'b0); expect_cycle("load.wb",   ST_WB,    S_RW | S_PCWE);
        drive(OP_LOAD, 1'b0, 1'b0, 1'b0); expect_cycle("load.next", ST_FETCH, S_IMEM);

        // store, zero-wait; retires on the dmem ack cycle without regwrite.
        drive(OP_STORE, 1'b1, 1'b0, 1'b0); expect_cycle("store.f",  ST_FETCH,   S_IMEM | S_IRWE);
        drive(OP_STORE, 1'b0, 1'b0, 1'b0); expect_cycle("store.d",  ST_DECODE,  S_NONE);
        drive(OP_STORE, 1'b0, 1'b0, 1'b0); expect_cycle("store.e",  ST_EXECUTE, S_NONE);
        drive(OP_STORE, 1'b0, 1'b1, 1'b0); expect_cycle("store.m",  ST_MEM,     S_DREQ | S_DWE | S_PCWE);

        // branch, taken then not taken: 3 cycles each, PC written in EXECUTE.
        for (int t = 1; t >= 0; t--) begin
            drive(OP_BRANCH, 1'b1, 1'b0, 1'(t)); expect_cycle("br.f", ST_FETCH,   S_IMEM | S_IRWE);
            drive(OP_BRANCH, 1'b0, 1'b0, 1'(t)); expect_cycle("br.d", ST_DECODE,  S_NONE);
            drive(OP_BRANCH, 1'b0, 1'b0, 1'(t)); expect_cycle("br.e", ST_EXECUTE, S_PCWE);
        end

        // jal goes through WB like rtype.
        drive(OP_JAL, 1'b1, 1'b0, 1'b0); expect_cycle("jal.f",  ST_FETCH,   S_IMEM | S_IRWE);
        drive(OP_JAL, 1'b0, 1'b0, 1'b0); expect_cycle("jal.d",  ST_DECODE,  S_NONE);
        drive(OP_JAL, 1'b0, 1'b0, 1'b0); expect_cycle("jal.e",  ST_EXECUTE, S_NONE);
        drive(OP_JAL, 1'b0, 1'b0, 1'b0); expect_cycle("jal.wb", ST_WB,      S_RW | S_PCWE);

        drive(OP_RTYPE, 1'b0, 1'b0, 1'b0); expect_cycle("idle", ST_FETCH, S_IMEM);
`ifdef MULTICYCLE_SEQUENCER_INSTRET_EN
        // Preload the counter to all-ones; the next retire must wrap it to 0.
        force dut.u_instret.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_instret.count_q;
        exp_ret = 32'hFFFF_FFFF;
`endif
        drive(OP_BRANCH, 1'b1, 1'b0, 1'b0); expect_cycle("wrap.f", ST_FETCH,   S_IMEM | S_IRWE);
        drive(OP_BRANCH, 1'b0, 1'b0, 1'b0); expect_cycle("wrap.d", ST_DECODE,  S_NONE);
        drive(OP_BRANCH, 1'b0, 1'b0, 1'b0); expect_cycle("wrap.e", ST_EXECUTE, S_PCWE);

        // Reset during a MEM wait abandons the access with no strobes.
        drive(OP_LOAD, 1'b1, 1'b0, 1'b0); expect_cycle("mrst.f", ST_FETCH,   S_IMEM | S_IRWE);
        check("wrap.value", instret_o, 32'd0);
        drive(OP_LOAD, 1'b0, 1'b0, 1'b0); expect_cycle("mrst.d", ST_DECODE,  S_NONE);
        drive(OP_LOAD, 1'b0, 1'b0, 1'b0); expect_cycle("mrst.e", ST_EXECUTE, S_NONE);
        drive(OP_LOAD, 1'b0, 1'b0, 1'b0); expect_cycle("mrst.m", ST_MEM,     S_DREQ);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        exp_ret = '0;
        expect_cycle("mrst.rst", ST_FETCH, S_IMEM);
        drive(OP_LOAD, 1'b0, 1'b1, 1'b0); expect_cycle("mrst.hold", ST_FETCH, S_IMEM);
        drive(OP_LOAD, 1'b0, 1'b0, 1'b0); expect_cycle("mrst.hold2", ST_FETCH, S_IMEM);
        rst_ni = 1'b1;

        // Illegal opcode traps; TRAP is sticky and ignores a stray fetch ack.
        drive(OP_RTYPE, 1'b1, 1'b0, 1'b0);         expect_cycle("trap.f", ST_FETCH,  S_IMEM | S_IRWE);
        drive(opcode_e'(7'h7F), 1'b0, 1'b0, 1'b0); expect_cycle("trap.d", ST_DECODE, S_NONE);
        for (int i = 0; i < 20; i++) begin
            drive(OP_RTYPE, (i == 5), (i == 9), 1'b0); expect_cycle("trap.hold", ST_TRAP, S_ILL);
        end
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        expect_cycle("trap.rst", ST_FETCH, S_IMEM);
        rst_ni = 1'b1;
        drive(OP_RTYPE, 1'b0, 1'b0, 1'b0); expect_cycle("trap.after", ST_FETCH, S_IMEM);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL: clk_i  input  1  single clock, all state rising-edge.
REQ-002 SHALL: rst_ni  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: opcodes_i  input  opcode enum (7)  opcode of the current instruction register.
REQ-004 SHALL: branch_taken_i  input  1  branch comparison result from datapath.
REQ-005 SHALL: imem_req_o  output  1  instruction fetch request.
REQ-006 SHALL: imem_ack_i  input  1  fetch complete, instruction data valid this cycle.
REQ-007 SHALL: dmem_req_o  output  1  data memory request.
REQ-008 SHALL: dmem_we_o  output  1  data memory write (store) qualifier.
REQ-009 SHALL: dmem_ack_i  input  1  data access complete.
REQ-010 SHALL: ir_we_o  output  1  instruction register load strobe.
REQ-011 SHALL: pc_we_o  output  1  PC update strobe, once per retired instruction.
REQ-012 SHALL: regwrite_o  output  1  register file write strobe.
REQ-013 SHALL: illegal_o  output  1  unknown opcode trapped.
REQ-014 SHALL: state_o  output  3  current FSM state, debug.
REQ-015 SHALL: instret_o  output  32  retired-instruction count (see Configuration).

Function
REQ-016 SHALL: States FETCH, DECODE, EXECUTE, MEM, WB, TRAP; all outputs Moore-decoded from state, except ir_we_o and pc_we_o, which are additionally qualified by the acks noted below.
REQ-017 SHALL: FETCH: imem_req_o=1 until imem_ack_i; ack cycle: ir_we_o=1 and next state DECODE; ack in the first request cycle is accepted (zero-wait).
REQ-018 SHALL: DECODE: 1 cycle; opcodes_i not in {rtype,itype,load,store,branch,jalr,jal,lui} -> TRAP, else -> EXECUTE.
REQ-019 SHALL: EXECUTE: 1 cycle; load/store -> MEM; branch -> FETCH with pc_we_o=1 (target vs PC+4 selected by datapath using branch_taken_i); all others -> WB.
REQ-020 SHALL: MEM: dmem_req_o=1 and dmem_we_o=(opcode==store) held stable until dmem_ack_i; on ack store -> FETCH with pc_we_o=1, load -> WB.
REQ-021 SHALL: WB: 1 cycle, regwrite_o=1, pc_we_o=1, -> FETCH.
REQ-022 SHALL: TRAP: illegal_o=1, every strobe and request 0, stays in TRAP until reset.
REQ-023 SHALL: imem_ack_i outside FETCH and dmem_ack_i outside MEM are ignored.
REQ-024 SHALL: zero-wait latencies are: branch 3, rtype/itype/lui/jal/jalr 4, store 4, load 5 cycles; each wait cycle adds exactly 1.
REQ-025 SHALL: opcodes_i is sampled only in DECODE, EXECUTE and MEM; a change in FETCH has no effect.

Reset
REQ-026 SHALL: on rst_ni low, state -> FETCH immediately; imem_req_o is 1 in the cycle after reset release; all other outputs are 0 and instret_o is 0.
REQ-027 SHALL: reset mid-access abandons the pending access without any pc_we_o, regwrite_o or ir_we_o pulse.

Configuration
REQ-028 SHALL: with MULTICYCLE_SEQUENCER_INSTRET_EN defined, a 32-bit counter increments on each cycle pc_we_o=1 and wraps 0xFFFF_FFFF -> 0.
REQ-029 SHALL: without MULTICYCLE_SEQUENCER_INSTRET_EN, no counter flops are built, instret_o is tied to 0 and the port list is unchanged.

Structure
REQ-030 SHALL: the state enum (3-bit, FETCH=0 .. TRAP=5) is added to the shared opcode package beside the opcode typedef.
REQ-031 SHALL: the instret counter is a separate sub-module, instret_counter, instantiated only under the macro.
REQ-032 SHALL: the FSM is implemented as one state register plus a combinational next-state/output block, with no further sub-modules.

Verification
REQ-033 SHALL: rtype with zero-wait acks -> states FETCH, DECODE, EXECUTE, WB; regwrite_o and pc_we_o high together only in cycle 4.
REQ-034 SHALL: load with dmem_ack_i delayed 3 cycles -> dmem_req_o high 4 cycles with dmem_we_o=0, then WB; total 8 cycles.
REQ-035 SHALL: store, zero-wait -> dmem_we_o=1 in MEM, pc_we_o=1 on the ack cycle, regwrite_o never 1.
REQ-036 SHALL: branch, both branch_taken_i values -> pc_we_o=1 in EXECUTE, 3 cycles, no regwrite_o.
REQ-037 SHALL: opcodes_i=7'h7F in DECODE -> TRAP, illegal_o held for 20 cycles, a stray imem_ack_i is ignored; rst_ni low -> FETCH.
REQ-038 SHALL: with the macro, a preloaded instret of 0xFFFF_FFFF plus one retire -> instret_o=0; rst_ni asserted during a MEM wait -> no strobes and instret_o=0.
